// File: rtl/core_finish_monitor.sv
// rtl/core_finish_monitor.sv - per-core completion monitor: run-cycle counting, end-PC detect, drain, done/all_done
//
// Optional feature macro: MONITOR_TIMEOUT_EN
//   defined   : a core that runs TIMEOUT_CYCLES-1 cycles without a match is
//               forced to a TIMEOUT state and reported done with timeout set.
//   undefined : no timeout comparator exists; timeout is tied to 0 and a core
//               that never matches stays in RUN until start or reset.
module core_finish_monitor #(
  parameter int NUM_CORES      = 2,
  parameter int ADDRESS_BITS   = 32,
  parameter int CYCLE_BITS     = 32,
  parameter int DRAIN_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0] PC,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0] end_address,
  output logic [NUM_CORES-1:0]              core_done,
  output logic                              all_done,
  output logic [NUM_CORES*CYCLE_BITS-1:0]   run_cycles,
  output logic [NUM_CORES-1:0]              timeout
);

  // Drain counter only needs to reach DRAIN_CYCLES-1; keep at least one bit.
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

`ifdef MONITOR_TIMEOUT_EN
  // Compare in a width wide enough for both the counter and the limit, so a
  // narrow counter never aliases onto a large limit through truncation.
  localparam int CMP_W = (CYCLE_BITS > 32) ? CYCLE_BITS : 32;
  localparam logic [CMP_W-1:0] TIMEOUT_LAST = CMP_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3
`ifdef MONITOR_TIMEOUT_EN
    ,
    S_TIMEOUT = 3'd4
`endif
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      state_t                r_state;
      logic [CYCLE_BITS-1:0] r_cnt;
      logic [DRAIN_W-1:0]    r_drain;
      logic [CYCLE_BITS-1:0] r_run_cycles;
      logic                  r_done;
      logic                  r_timeout;
      logic                  w_match;

      assign w_match = (PC[gi*ADDRESS_BITS +: ADDRESS_BITS] ==
                        end_address[gi*ADDRESS_BITS +: ADDRESS_BITS]);

      // Per-core FSM: reset beats start, start beats any match, outputs registered.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_drain      <= '0;
          r_run_cycles <= '0;
          r_done       <= 1'b0;
          r_timeout    <= 1'b0;
        end else if (start) begin
          r_state      <= S_RUN;
          r_cnt        <= '0;
          r_drain      <= '0;
          r_run_cycles <= '0;
          r_done       <= 1'b0;
          r_timeout    <= 1'b0;
        end else begin
          case (r_state)
            S_RUN: begin
              if (w_match) begin
                r_run_cycles <= r_cnt;
                r_drain      <= '0;
                r_state      <= S_DRAIN;
`ifdef MONITOR_TIMEOUT_EN
              end else if (CMP_W'(r_cnt) == TIMEOUT_LAST) begin
                r_run_cycles <= r_cnt;
                r_timeout    <= 1'b1;
                r_done       <= 1'b1;
                r_state      <= S_TIMEOUT;
`endif
              end else if (r_cnt != {CYCLE_BITS{1'b1}}) begin
                // Saturate rather than wrap so a runaway core reads as "very long".
                r_cnt <= r_cnt + 1'b1;
              end
            end
            S_DRAIN: begin
              if (r_drain == DRAIN_LAST) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_drain <= r_drain + 1'b1;
              end
            end
            default: begin
              // IDLE, DONE and TIMEOUT hold until start or reset.
              r_state <= r_state;
            end
          endcase
        end
      end

      assign core_done[gi]                                 = r_done;
      assign timeout[gi]                                   = r_timeout;
      assign run_cycles[gi*CYCLE_BITS +: CYCLE_BITS]       = r_run_cycles;
    end
  endgenerate

  // Aggregate completion, registered one cycle behind core_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      all_done <= 1'b0;
    end else begin
      all_done <= &core_done;
    end
  end

endmodule
